// File: rtl/instr_encoder.sv
// RV32I instruction word encoder with an output FIFO and emitted-word counter.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       fmt,
    input  logic [6:0]       op,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr,
    output logic             err,
    output logic [CNT_W-1:0] instr_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_OCC = (AW+1)'(DEPTH);

    logic [31:0] w_word;
    logic        w_err;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;

    logic [32:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_occ;
    logic [CNT_W-1:0] r_cnt;

    // Illegal formats fall through to the canonical NOP with the error flag.
    always_comb begin
        w_word = 32'h0000_0013;
        w_err  = 1'b1;
        case (fmt)
            3'b000: begin w_word = {funct7, rs2, rs1, funct3, rd, op}; w_err = 1'b0; end
            3'b001: begin w_word = {imm[11:0], rs1, funct3, rd, op}; w_err = 1'b0; end
            3'b010: begin w_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], op}; w_err = 1'b0; end
            3'b011: begin
                w_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op};
                w_err  = 1'b0;
            end
            3'b100: begin w_word = {imm[31:12], rd, op}; w_err = 1'b0; end
            3'b101: begin
                w_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                w_err  = 1'b0;
            end
            default: ;
        endcase
`ifdef ENC_RANGE_CHECK_EN
        // Word stays encoded with truncated fields; only the flag is raised.
        case (fmt)
            3'b001, 3'b010: if (imm[31:11] != {21{imm[11]}}) w_err = 1'b1;
            3'b011: if (imm[31:12] != {20{imm[12]}} || imm[0]) w_err = 1'b1;
            3'b100: if (imm[11:0] != 12'd0) w_err = 1'b1;
            3'b101: if (imm[31:20] != {12{imm[20]}} || imm[0]) w_err = 1'b1;
            default: ;
        endcase
`endif
    end

    assign w_full    = (r_occ == FULL_OCC);
    assign w_empty   = (r_occ == '0);
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign w_push    = in_valid && !w_full;
    assign w_pop     = !w_empty && out_ready;

    assign instr       = w_empty ? 32'd0 : r_mem[r_rptr][31:0];
    assign err         = w_empty ? 1'b0  : r_mem[r_rptr][32];
    assign instr_count = r_cnt;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= {w_err, w_word};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_occ  <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= (r_wptr == AW'(DEPTH-1)) ? '0 : r_wptr + 1'b1;
            if (w_pop) begin
                r_rptr <= (r_rptr == AW'(DEPTH-1)) ? '0 : r_rptr + 1'b1;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
            else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, FIFO/reset sequences, and
// randomized traffic against a queue-based reference model.
module tb_instr_encoder;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready, err;
    logic [2:0]  fmt, funct3;
    logic [6:0]  op, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm, instr;
    logic [CNT_W-1:0] instr_count;

    int n_vec = 0;
    int n_bad = 0;

    instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .op(op), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready),
        .instr(instr), .err(err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [31:0] exp_instr;
        logic        exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] f, input logic [6:0] o, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
        fmt = f; op = o; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Reference encoder built from shifts/masks and signed integer range tests.
    function automatic logic [32:0] model(input logic [2:0] f, input logic [6:0] o,
            input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
            input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im);
        logic [31:0] w;
        logic        e;
        int          s;
        s = $signed(im);
        w = 32'(o);
        e = 1'b0;
        case (f)
            3'd0: w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                      | (32'(s2) << 20) | (32'(f7) << 25);
            3'd1: w = w | (32'(d) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                      | ((im & 32'hFFF) << 20);
            3'd2: w = w | ((im & 32'h1F) << 7) | (32'(f3) << 12) | (32'(s1) << 15)
                      | (32'(s2) << 20) | (((im >> 5) & 32'h7F) << 25);
            3'd3: w = w | (((im >> 11) & 32'h1) << 7) | (((im >> 1) & 32'hF) << 8)
                      | (32'(f3) << 12) | (32'(s1) << 15) | (32'(s2) << 20)
                      | (((im >> 5) & 32'h3F) << 25) | (((im >> 12) & 32'h1) << 31);
            3'd4: w = w | (32'(d) << 7) | (im & 32'hFFFF_F000);
            3'd5: w = w | (32'(d) << 7) | (((im >> 12) & 32'hFF) << 12)
                      | (((im >> 11) & 32'h1) << 20) | (((im >> 1) & 32'h3FF) << 21)
                      | (((im >> 20) & 32'h1) << 31);
            default: begin w = 32'h13; e = 1'b1; end
        endcase
`ifdef ENC_RANGE_CHECK_EN
        case (f)
            3'd1, 3'd2: if (s < -2048 || s > 2047) e = 1'b1;
            3'd3: if (s < -4096 || s > 4095 || (s % 2) != 0) e = 1'b1;
            3'd4: if ((im % 4096) != 0) e = 1'b1;
            3'd5: if (s < -(1 << 20) || s >= (1 << 20) || (s % 2) != 0) e = 1'b1;
            default: ;
        endcase
`endif
        return {e, w};
    endfunction

    logic [32:0] q[$];
    logic [CNT_W-1:0] m_cnt;

    initial begin
        vecs[0] = '{3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h00500093, 1'b0};
        vecs[1] = '{3'b000, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 32'h002081B3, 1'b0};
        vecs[2] = '{3'b010, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 32'h0020A423, 1'b0};
        vecs[3] = '{3'b011, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE000EE3, 1'b0};
        vecs[4] = '{3'b100, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 32'h123452B7, 1'b0};
        vecs[5] = '{3'b110, 7'b0110011, 5'd7, 5'd7, 5'd7, 3'd7, 7'd0, 32'd0, 32'h00000013, 1'b1};
        vecs[6] = '{3'b101, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h008000EF, 1'b0};
`ifdef ENC_RANGE_CHECK_EN
        vecs[7] = '{3'b001, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h80000013, 1'b1};
`else
        vecs[7] = '{3'b001, 7'b0010011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 32'h80000013, 1'b0};
`endif

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(instr_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Directed table: each vector is visible at the head one edge after accept.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(vecs[i].fmt, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
                  vecs[i].f3, vecs[i].f7, vecs[i].imm);
            in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk($sformatf("vec%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk($sformatf("vec%0d_drained", i), 32'(out_valid), 32'd0);
        end

        // Fill to full with the consumer stalled, then drain in order.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            drive(3'b001, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'(k + 1));
            in_valid = 1'b1;
            chk($sformatf("fill%0d_in_ready", k), 32'(in_ready), (k < DEPTH) ? 32'd1 : 32'd0);
            if (k > 0) chk($sformatf("fill%0d_head_stable", k), instr, 32'h00100093);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("full_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("drain%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("drain%0d_instr", k), instr, 32'h00000093 | (32'(k + 1) << 20));
            @(negedge clk);
        end
        out_ready = 1'b0;
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_count", 32'(instr_count), 32'd4);

        // Asynchronous reset with three entries queued.
        for (int k = 0; k < 3; k++) begin
            drive(3'b000, 7'b0110011, 5'(k), 5'd1, 5'd2, 3'd0, 7'd0, 32'd0);
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_count", 32'(instr_count), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        chk("async_rst_instr", instr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic against the queue model.
        q.delete();
        m_cnt = '0;
        for (int c = 0; c < 600; c++) begin
            logic [31:0] rimm;
            logic        push, pop;
            @(negedge clk);
            chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("rnd_instr", instr, (q.size() != 0) ? q[0][31:0] : 32'd0);
            chk("rnd_err", 32'(err), (q.size() != 0) ? 32'(q[0][32]) : 32'd0);
            chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            chk("rnd_count", 32'(instr_count), 32'(m_cnt));
            case ($urandom_range(0, 3))
                0: rimm = 32'($signed($urandom_range(0, 64)) - 32) & 32'hFFFF_FFFE;
                1: rimm = $urandom;
                2: rimm = $urandom & 32'hFFFF_F000;
                default: rimm = 32'($signed($urandom_range(0, 8191)) - 4096);
            endcase
            drive(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                  5'($urandom), 3'($urandom), 7'($urandom), rimm);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = (c < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            push = in_valid && (q.size() < DEPTH);
            pop  = out_ready && (q.size() != 0);
            @(posedge clk);
            if (pop) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (push) q.push_back(model(fmt, op, rd, rs1, rs2, funct3, funct7, imm));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
